// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and the buffered write-back entry layout for the
// register-file write-back arbiter and its Mem-source FIFO.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rg;
        logic [DATA_W-1:0]     data;
    } wbEntry_t;

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// In-order Mem-source result buffer: DEPTH entries, wrap-bit pointers,
// asynchronous active-low reset discards all buffered entries.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     Clock,
    input  logic     Reset,
    input  logic     PushEn,
    input  wbEntry_t PushEntry,
    input  logic     PopEn,
    output wbEntry_t HeadEntry,
    output logic     Full,
    output logic     Empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wrPtr;
    logic [AW:0]   rdPtr;
    logic [AW:0]   count;
    wbEntry_t      mem [DEPTH];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (PushEn) wrPtr <= wrPtr + 1'b1;
            if (PopEn)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge Clock) begin
        if (PushEn) mem[wrPtr[AW-1:0]] <= PushEntry;
    end

    assign count     = wrPtr - rdPtr;
    assign Full      = (count == (AW+1)'(DEPTH));
    assign Empty     = (count == '0);
    assign HeadEntry = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/writeback_arbiter.sv
// Drives the register-file write port from the ALU (priority) and a buffered
// Mem source, with a starvation guard and a per-register Busy scoreboard.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  AluValid,
    output logic                  AluReady,
    input  logic [REG_ADDR_W-1:0] AluRg,
    input  logic [DATA_W-1:0]     AluData,
    input  logic                  MemValid,
    output logic                  MemReady,
    input  logic [REG_ADDR_W-1:0] MemRg,
    input  logic [DATA_W-1:0]     MemData,
    input  logic                  IssueValid,
    input  logic [REG_ADDR_W-1:0] IssueRg,
    output logic [NUM_REGS-1:0]   Busy,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRg,
    output logic [DATA_W-1:0]     WriteData
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  memPush;
    logic                  memPop;
    logic                  aluWin;
    logic                  starved;
    wbEntry_t              pushEntry;
    wbEntry_t              headEntry;
    logic [SW-1:0]         starveCnt;
    logic [SW-1:0]         starveCntNext;
    logic [NUM_REGS-1:0]   busyReg;
    logic [NUM_REGS-1:0]   busyNext;
    logic                  regWriteNext;
    logic [REG_ADDR_W-1:0] writeRgNext;
    logic [DATA_W-1:0]     writeDataNext;

    // Handshake: a transfer happens on the rising edge of any cycle in which
    // Valid and Ready are both high; Ready depends only on internal state, never
    // on the same-cycle Valid, and a producer holds its payload until accepted.
    assign starved  = (starveCnt == SW'(STARVE_LIMIT)) && !fifoEmpty;
    assign AluReady = !starved;
    assign MemReady = !fifoFull;
    assign aluWin   = AluValid && AluReady;
    assign memPush  = MemValid && MemReady;
    assign memPop   = !aluWin && !fifoEmpty;

    assign pushEntry.rg   = MemRg;
    assign pushEntry.data = MemData;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) uFifo (
        .Clock    (Clock),
        .Reset    (Reset),
        .PushEn   (memPush),
        .PushEntry(pushEntry),
        .PopEn    (memPop),
        .HeadEntry(headEntry),
        .Full     (fifoFull),
        .Empty    (fifoEmpty)
    );

    // Counts ALU wins that left a waiting FIFO head behind.
    always_comb begin
        starveCntNext = starveCnt;
        if (fifoEmpty || memPop) begin
            starveCntNext = '0;
        end else if (aluWin) begin
            starveCntNext = starveCnt + 1'b1;
        end
    end

    always_comb begin
        regWriteNext  = 1'b0;
        writeRgNext   = WriteRg;
        writeDataNext = WriteData;
        if (aluWin) begin
            regWriteNext  = (AluRg != '0);
            writeRgNext   = AluRg;
            writeDataNext = AluData;
        end else if (memPop) begin
            regWriteNext  = (headEntry.rg != '0);
            writeRgNext   = headEntry.rg;
            writeDataNext = headEntry.data;
        end
    end

    // A new issue to a register retiring this cycle must stay busy, so set wins.
    always_comb begin
        busyNext = busyReg;
        if (memPop && (headEntry.rg != '0)) busyNext[headEntry.rg] = 1'b0;
        if (IssueValid && (IssueRg != '0))  busyNext[IssueRg]      = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            starveCnt <= '0;
            busyReg   <= '0;
            RegWrite  <= 1'b0;
            WriteRg   <= '0;
            WriteData <= '0;
        end else begin
            starveCnt <= starveCntNext;
            busyReg   <= busyNext;
            RegWrite  <= regWriteNext;
            WriteRg   <= writeRgNext;
            WriteData <= writeDataNext;
        end
    end

    assign Busy = busyReg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: ALU vector table plus hand-derived
// sequences for latency, scoreboard, starvation, full-FIFO and mid-run reset.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic                  Clock = 1'b0;
    logic                  Reset = 1'b0;
    logic                  AluValid = 1'b0;
    logic                  AluReady;
    logic [REG_ADDR_W-1:0] AluRg = '0;
    logic [DATA_W-1:0]     AluData = '0;
    logic                  MemValid = 1'b0;
    logic                  MemReady;
    logic [REG_ADDR_W-1:0] MemRg = '0;
    logic [DATA_W-1:0]     MemData = '0;
    logic                  IssueValid = 1'b0;
    logic [REG_ADDR_W-1:0] IssueRg = '0;
    logic [NUM_REGS-1:0]   Busy;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] WriteRg;
    logic [DATA_W-1:0]     WriteData;

    int compared   = 0;
    int mismatched = 0;
    logic [ENTRY_W-1:0] exp_q[$];
    logic allowReissue = 1'b0;

    typedef struct {
        logic                  aluValid;
        logic [REG_ADDR_W-1:0] aluRg;
        logic [DATA_W-1:0]     aluData;
        logic                  expRegWrite;
        logic                  checkAddr;
        logic [REG_ADDR_W-1:0] expRg;
        logic [DATA_W-1:0]     expData;
    } aluVec_t;

    aluVec_t aluVecs[6];

    writeback_arbiter #(
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .AluValid  (AluValid),
        .AluReady  (AluReady),
        .AluRg     (AluRg),
        .AluData   (AluData),
        .MemValid  (MemValid),
        .MemReady  (MemReady),
        .MemRg     (MemRg),
        .MemData   (MemData),
        .IssueValid(IssueValid),
        .IssueRg   (IssueRg),
        .Busy      (Busy),
        .RegWrite  (RegWrite),
        .WriteRg   (WriteRg),
        .WriteData (WriteData)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idleInputs();
        AluValid   = 1'b0;
        AluRg      = '0;
        AluData    = '0;
        MemValid   = 1'b0;
        MemRg      = '0;
        MemData    = '0;
        IssueValid = 1'b0;
        IssueRg    = '0;
    endtask

    task automatic expectMemWrite(input string name);
        logic [ENTRY_W-1:0] e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: write seen with empty expected queue, got rg %0d", name, WriteRg);
        end else begin
            e = exp_q.pop_front();
            check({name, "_rg"}, 32'(WriteRg), 32'(e[ENTRY_W-1:DATA_W]));
            check({name, "_data"}, WriteData, e[DATA_W-1:0]);
        end
    endtask

    // Decode must never issue to a register the scoreboard still holds busy.
    always @(negedge Clock) begin
        if (Reset && IssueValid && (IssueRg != '0) && !allowReissue) begin
            compared++;
            if (Busy[IssueRg]) begin
                mismatched++;
                $display("FAIL issue_to_busy: rg %0d busy=1, required 0", IssueRg);
            end
        end
    end

    initial begin
        aluVecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1, 1'b1, 5'd5,  32'h0000_1234};
        aluVecs[1] = '{1'b0, 5'd7,  32'h0000_0099, 1'b0, 1'b1, 5'd5,  32'h0000_1234};
        aluVecs[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};
        aluVecs[3] = '{1'b1, 5'd0,  32'h0000_5555, 1'b0, 1'b0, 5'd0,  32'h0000_0000};
        aluVecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 1'b1, 5'd1,  32'h0000_0000};
        aluVecs[5] = '{1'b0, 5'd2,  32'h0000_0077, 1'b0, 1'b1, 5'd1,  32'h0000_0000};

        // Reset state and first cycle after release
        idleInputs();
        Reset = 1'b0;
        repeat (2) tick();
        check("reset_regwrite", 32'(RegWrite), 32'd0);
        check("reset_writerg", 32'(WriteRg), 32'd0);
        check("reset_writedata", WriteData, 32'd0);
        check("reset_busy", Busy, 32'd0);
        Reset = 1'b1;
        #1;
        check("release_aluready", 32'(AluReady), 32'd1);
        check("release_memready", 32'(MemReady), 32'd1);
        tick();
        check("release_regwrite", 32'(RegWrite), 32'd0);

        // ALU vector table: one-cycle latency, reg-0 suppression, hold when idle
        for (int i = 0; i < 6; i++) begin
            AluValid = aluVecs[i].aluValid;
            AluRg    = aluVecs[i].aluRg;
            AluData  = aluVecs[i].aluData;
            #1;
            check($sformatf("alu%0d_aluready", i), 32'(AluReady), 32'd1);
            tick();
            check($sformatf("alu%0d_regwrite", i), 32'(RegWrite), 32'(aluVecs[i].expRegWrite));
            if (aluVecs[i].checkAddr) begin
                check($sformatf("alu%0d_writerg", i), 32'(WriteRg), 32'(aluVecs[i].expRg));
                check($sformatf("alu%0d_writedata", i), WriteData, aluVecs[i].expData);
            end
        end
        idleInputs();

        // Scoreboard and Mem latency: issue rg8, push, retire two edges later
        IssueValid = 1'b1;
        IssueRg    = 5'd8;
        tick();
        check("busy8_set", Busy, 32'h0000_0100);
        IssueValid = 1'b0;
        MemValid   = 1'b1;
        MemRg      = 5'd8;
        MemData    = 32'hDEAD_BEEF;
        #1;
        check("mem8_memready", 32'(MemReady), 32'd1);
        tick();
        check("mem8_t1_regwrite", 32'(RegWrite), 32'd0);
        check("mem8_t1_busy", Busy, 32'h0000_0100);
        MemValid = 1'b0;
        tick();
        check("mem8_t2_regwrite", 32'(RegWrite), 32'd1);
        check("mem8_t2_writerg", 32'(WriteRg), 32'd8);
        check("mem8_t2_writedata", WriteData, 32'hDEAD_BEEF);
        check("mem8_t2_busy", Busy, 32'd0);
        tick();
        check("mem8_t3_regwrite", 32'(RegWrite), 32'd0);
        check("mem8_t3_hold_rg", 32'(WriteRg), 32'd8);
        check("mem8_t3_hold_data", WriteData, 32'hDEAD_BEEF);

        IssueValid = 1'b1;
        IssueRg    = 5'd0;
        tick();
        check("issue_rg0_busy", Busy, 32'd0);

        // Set wins over a same-edge retire to rg9
        IssueRg = 5'd9;
        tick();
        check("busy9_set", Busy, 32'h0000_0200);
        IssueValid = 1'b0;
        MemValid   = 1'b1;
        MemRg      = 5'd9;
        MemData    = 32'h0000_9999;
        tick();
        check("busy9_pushed", Busy, 32'h0000_0200);
        MemValid     = 1'b0;
        IssueValid   = 1'b1;
        IssueRg      = 5'd9;
        allowReissue = 1'b1;
        tick();
        check("busy9_retire_regwrite", 32'(RegWrite), 32'd1);
        check("busy9_retire_writerg", 32'(WriteRg), 32'd9);
        check("busy9_set_wins", Busy, 32'h0000_0200);
        idleInputs();
        allowReissue = 1'b0;

        // Starvation guard: ALU held valid, four Mem entries drain one per 4 cycles
        for (int c = 0; c < 18; c++) begin
            logic expAluReady;
            logic expMemReady;
            AluValid    = 1'b1;
            AluRg       = 5'd20;
            AluData     = 32'hA000 + 32'(c);
            MemValid    = (c < 4);
            MemRg       = 5'(c + 1);
            MemData     = 32'hB000 + 32'(c + 1);
            expAluReady = !((c >= 4) && (c % 4 == 0));
            expMemReady = (c != 4);
            if (MemValid && expMemReady) exp_q.push_back({MemRg, MemData});
            #1;
            check($sformatf("starve%0d_aluready", c), 32'(AluReady), 32'(expAluReady));
            check($sformatf("starve%0d_memready", c), 32'(MemReady), 32'(expMemReady));
            tick();
            check($sformatf("starve%0d_regwrite", c), 32'(RegWrite), 32'd1);
            if (expAluReady) begin
                check($sformatf("starve%0d_alu_rg", c), 32'(WriteRg), 32'd20);
                check($sformatf("starve%0d_alu_data", c), WriteData, 32'hA000 + 32'(c));
            end else begin
                expectMemWrite($sformatf("starve%0d_mem", c));
            end
            check($sformatf("starve%0d_busy", c), Busy, 32'h0000_0200);
        end
        check("starve_queue_drained", 32'(exp_q.size()), 32'd0);
        idleInputs();

        // Full FIFO pops with MemValid held: refused that cycle, accepted next
        for (int c = 0; c < 10; c++) begin
            logic expReady;
            AluValid = (c <= 4);
            AluRg    = 5'd20;
            AluData  = 32'hA100 + 32'(c);
            MemValid = (c <= 5);
            MemRg    = (c < 4) ? 5'(c + 1) : 5'd5;
            MemData  = 32'hC000 + 32'(MemRg);
            expReady = (c != 4);
            if (MemValid && expReady) exp_q.push_back({MemRg, MemData});
            #1;
            check($sformatf("full%0d_memready", c), 32'(MemReady), 32'(expReady));
            check($sformatf("full%0d_aluready", c), 32'(AluReady), 32'(expReady));
            tick();
            if (c < 4) begin
                check($sformatf("full%0d_alu_rg", c), 32'(WriteRg), 32'd20);
                check($sformatf("full%0d_alu_data", c), WriteData, 32'hA100 + 32'(c));
            end else if (c <= 8) begin
                check($sformatf("full%0d_regwrite", c), 32'(RegWrite), 32'd1);
                expectMemWrite($sformatf("full%0d_mem", c));
            end else begin
                check($sformatf("full%0d_idle_regwrite", c), 32'(RegWrite), 32'd0);
            end
        end
        check("full_queue_drained", 32'(exp_q.size()), 32'd0);
        idleInputs();

        // Reset mid-stream with three buffered entries: nothing is written
        for (int c = 0; c < 3; c++) begin
            AluValid = 1'b1;
            AluRg    = 5'd21;
            AluData  = 32'hA200 + 32'(c);
            MemValid = 1'b1;
            MemRg    = 5'(c + 11);
            MemData  = 32'hD000 + 32'(c);
            tick();
        end
        idleInputs();
        Reset = 1'b0;
        #1;
        check("midrst_regwrite", 32'(RegWrite), 32'd0);
        check("midrst_writerg", 32'(WriteRg), 32'd0);
        check("midrst_writedata", WriteData, 32'd0);
        check("midrst_busy", Busy, 32'd0);
        check("midrst_memready", 32'(MemReady), 32'd1);
        tick();
        Reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("postrst%0d_regwrite", c), 32'(RegWrite), 32'd0);
        end
        check("postrst_aluready", 32'(AluReady), 32'd1);
        check("postrst_memready", 32'(MemReady), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
